cp0_exception_commit: RTL
=========================

# cp0_exception_commit

Consumer end of the exception path: takes the prioritised `exception_info` record and `is_eret` produced by exception detection at the commit stage. It updates the CP0 architectural registers (Status, Cause, EPC, BadVAddr, Count, Compare) and issues the pipeline redirect PC. It closes the loop by returning `cp0_status` and the pending/enabled `interrupt_info` vector to detection. It also serves MFC0 reads and MTC0 writes and owns the Count/Compare timer interrupt.

## Interface
- `EXC_BASE`, 32'hBFC0_0200, exception vector base (BEV=1 fixed).
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `exception_info`  in  struct  `{valid, location, pc, in_delay_slot, code, badvaddr}` from detection; `location` selects the refill (offset 0x000) or general (offset 0x180) vector.
- `is_eret`  in  1  ERET committing this cycle.
- `ext_int`  in  6  hardware interrupt lines, level-sensitive; bits [4:0] map to IP[6:2], bit 5 is ignored because IP7 is the timer.
- `mtc0_wen`, `mtc0_addr[4:0]`, `mtc0_data[31:0]`  in  MTC0 write port, sel=0 only.
- `mfc0_addr`  in  5  read address.
- `mfc0_rdata`  out  32  combinational read data; unimplemented address → 0.
- `cp0_status`  out  `cp0_status_t`  current Status (IE, EXL, ERL, IM, BEV).
- `interrupt_info`  out  8  Cause.IP & Status.IM.
- `redirect_valid`  out  1  flush and redirect this cycle.
- `redirect_pc`  out  32  target PC.

## Operation
- Reset values:
  - Status = 32'h0040_0000 (BEV=1, all other bits 0).
  - Cause = EPC = BadVAddr = Count = Compare = 0.
  - Internal count-phase bit = 0; TI = 0.
  - `redirect_valid` = 0.
- Commit priority each cycle: `exception_info.valid` > `is_eret` > `mtc0_wen`. A lower-priority event in the same cycle is dropped entirely.
- Exception commit (valid=1):
  - If Status.EXL=0: EPC ← `in_delay_slot` ? pc−4 : pc, and Cause.BD ← `in_delay_slot`.
  - If Status.EXL=1: EPC and BD are unchanged.
  - Always: Cause.ExcCode ← code; Status.EXL ← 1.
  - BadVAddr ← badvaddr only for codes ADEL, ADES, TLBL, TLBS, MOD; unchanged for all others.
  - `redirect_valid`=1; `redirect_pc` = EXC_BASE + (location refill and EXL=0 ? 0x000 : 0x180).
- ERET (no exception): Status.EXL ← 0; `redirect_valid`=1; `redirect_pc` = EPC as held before this edge.
- MTC0 writable fields; all other bits read back unchanged:
  - Status: IM[15:8], EXL[1], IE[0].
  - Cause: IP[9:8].
  - EPC (14), BadVAddr (8) and Count (9): full word; BadVAddr is writable for simplicity.
  - Compare (11): full word, and the write clears TI.
- Timer:
  - The phase bit toggles every cycle; Count increments when phase=1, i.e. at half the clock rate. Count wraps from 0xFFFF_FFFF to 0.
  - TI sets when Count == Compare after an update and holds until a Compare write.
  - An MTC0 to Count takes precedence over the increment in that cycle.
- Cause.IP[7] = TI. Cause.IP[6:2] = `ext_int[4:0]`, registered every cycle. Cause.IP[1:0] are software bits.
- Cause.TI (bit 30) mirrors TI.

## Timing
- `redirect_valid`/`redirect_pc` are combinational from the commit inputs in the same cycle.
- All register updates land at the next rising edge. An MFC0 in the cycle after an MTC0 returns the new value; there is no bypass within the same cycle.
- `interrupt_info` reflects `ext_int` with 1 cycle of latency and TI with 1 cycle of latency.
- Reset mid-operation: all state returns to reset values at that edge; `redirect_valid` is 0 while `reset` is high.
- The block has no backpressure; exactly one commit is accepted per cycle.

## Structure
- `cp0_pkg`:
  - `cp0_status_t` and `cp0_cause_t` packed structs.
  - Register address constants (CP0_BADVADDR=8, CP0_COUNT=9, CP0_COMPARE=11, CP0_STATUS=12, CP0_CAUSE=13, CP0_EPC=14).
  - Vector offsets.
- Exception codes are reused from `exception_pkg`.
- One sub-module, `cp0_timer`: phase bit, Count, Compare, TI, and its write ports.

## Test plan
- Reset, then MFC0 12 → 32'h0040_0000; MFC0 13 → 0.
- Exception: code=ADEL, pc=32'h8000_0010, in_delay_slot=1, badvaddr=32'h8000_0013, EXL=0.
  - Same cycle: redirect_pc=32'hBFC0_0380.
  - Next cycle: EPC=32'h8000_000C, Cause.BD=1, ExcCode=4, BadVAddr=32'h8000_0013, EXL=1.
- Second exception (SYS) while EXL=1 → EPC unchanged, ExcCode=8, redirect to 0xBFC0_0380. Then ERET → redirect_pc=EPC, EXL=0 the next cycle.
- Timer: MTC0 Compare=4 with Count=0 → TI=1 and IP[7]=1 after 8 cycles. MTC0 Compare → TI=0 the next cycle.
- Exception, ERET and MTC0 Status asserted in the same cycle → only the exception effects occur; Status.IM is unchanged.
- Interrupts: ext_int=6'b000001 with IM[2]=1 → interrupt_info=8'h04 one cycle later. MTC0 Cause=32'h100 with IM[0]=1 → interrupt_info bit0=1.

Source files
------------

// File: rtl/cp0_pkg.sv
// cp0_pkg: CP0 register layouts, register addresses and exception vector offsets
package cp0_pkg;
  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;
  localparam logic [31:0] VEC_REFILL  = 32'h0000_0000;
  localparam logic [31:0] VEC_GENERAL = 32'h0000_0180;
  typedef struct packed {
    logic [8:0] rsvd_hi;
    logic       bev;
    logic [5:0] rsvd_mid;
    logic [7:0] im;
    logic [4:0] rsvd_lo;
    logic       erl;
    logic       exl;
    logic       ie;
  } cp0_status_t;
  typedef struct packed {
    logic        bd;
    logic        ti;
    logic [13:0] rsvd_hi;
    logic [7:0]  ip;
    logic        rsvd_mid;
    logic [4:0]  exc_code;
    logic [1:0]  rsvd_lo;
  } cp0_cause_t;
endpackage

// File: rtl/exception_pkg.sv
// exception_pkg: exception codes and the detection-to-commit exception record
package exception_pkg;
  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_MOD  = 5'd1,
    EXC_TLBL = 5'd2,
    EXC_TLBS = 5'd3,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_IBE  = 5'd6,
    EXC_DBE  = 5'd7,
    EXC_SYS  = 5'd8,
    EXC_BP   = 5'd9,
    EXC_RI   = 5'd10,
    EXC_CPU  = 5'd11,
    EXC_OV   = 5'd12
  } exc_code_e;
  typedef enum logic {
    LOC_GENERAL = 1'b0,
    LOC_REFILL  = 1'b1
  } exc_location_e;
  typedef struct packed {
    logic          valid;
    exc_location_e location;
    logic [31:0]   pc;
    logic          in_delay_slot;
    exc_code_e     code;
    logic [31:0]   badvaddr;
  } exception_info_t;
  function automatic logic sets_badvaddr(exc_code_e c);
    return c inside {EXC_ADEL, EXC_ADES, EXC_TLBL, EXC_TLBS, EXC_MOD};
  endfunction
endpackage

// File: rtl/cp0_timer.sv
// cp0_timer: half-rate Count, Compare and the sticky timer interrupt
module cp0_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        count_wen,
  input  logic        compare_wen,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);
  logic        phase_q, phase_d, ti_q, ti_d;
  logic [31:0] count_q, count_d, compare_q, compare_d;
  always_comb begin
    phase_d   = !phase_q;
    count_d   = count_wen ? wdata : count_q + {31'd0, phase_q};
    compare_d = compare_wen ? wdata : compare_q;
    ti_d      = compare_wen ? 1'b0 : ti_q | ((count_wen | phase_q) && count_d == compare_q);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q   <= 1'b0;
      count_q   <= '0;
      compare_q <= '0;
      ti_q      <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
    end
  end
  assign count   = count_q;
  assign compare = compare_q;
  assign ti      = ti_q;
endmodule

// File: rtl/cp0_exception_commit.sv
// cp0_exception_commit: commits exceptions/ERET/MTC0 into CP0 state and drives the redirect
module cp0_exception_commit
  import cp0_pkg::*;
  import exception_pkg::*;
#(
  parameter logic [31:0] EXC_BASE = 32'hBFC0_0200
) (
  input  logic            clk,
  input  logic            reset,
  input  exception_info_t exception_info,
  input  logic            is_eret,
  input  logic [5:0]      ext_int,
  input  logic            mtc0_wen,
  input  logic [4:0]      mtc0_addr,
  input  logic [31:0]     mtc0_data,
  input  logic [4:0]      mfc0_addr,
  output logic [31:0]     mfc0_rdata,
  output cp0_status_t     cp0_status,
  output logic [7:0]      interrupt_info,
  output logic            redirect_valid,
  output logic [31:0]     redirect_pc
);
  logic        exc, eret, mtc, unused, ti;
  logic        exl_q, exl_d, ie_q, ie_d, bd_q, bd_d;
  logic [7:0]  im_q, im_d;
  logic [4:0]  exc_code_q, exc_code_d, ip_hw_q, ip_hw_d;
  logic [1:0]  ip_sw_q, ip_sw_d;
  logic [31:0] epc_q, epc_d, badvaddr_q, badvaddr_d, count, compare;
  cp0_cause_t  cause;
  assign exc    = exception_info.valid;
  assign eret   = !exc && is_eret;
  assign mtc    = !exc && !is_eret && mtc0_wen;
  assign unused = ext_int[5];
  cp0_timer u_timer (
    .clk         (clk),
    .reset       (reset),
    .count_wen   (mtc && mtc0_addr == CP0_COUNT),
    .compare_wen (mtc && mtc0_addr == CP0_COMPARE),
    .wdata       (mtc0_data),
    .count       (count),
    .compare     (compare),
    .ti          (ti)
  );
  always_comb begin
    im_d       = im_q;
    ie_d       = ie_q;
    exl_d      = exl_q;
    bd_d       = bd_q;
    exc_code_d = exc_code_q;
    ip_sw_d    = ip_sw_q;
    ip_hw_d    = ext_int[4:0];
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;
    if (exc) begin
      if (!exl_q) begin
        epc_d = exception_info.in_delay_slot ? exception_info.pc - 32'd4 : exception_info.pc;
        bd_d  = exception_info.in_delay_slot;
      end
      exc_code_d = exception_info.code;
      exl_d      = 1'b1;
      badvaddr_d = sets_badvaddr(exception_info.code) ? exception_info.badvaddr : badvaddr_q;
    end else if (eret) begin
      exl_d = 1'b0;
    end else if (mtc) begin
      if (mtc0_addr == CP0_STATUS) begin
        im_d  = mtc0_data[15:8];
        exl_d = mtc0_data[1];
        ie_d  = mtc0_data[0];
      end
      ip_sw_d    = mtc0_addr == CP0_CAUSE ? mtc0_data[9:8] : ip_sw_q;
      epc_d      = mtc0_addr == CP0_EPC ? mtc0_data : epc_q;
      badvaddr_d = mtc0_addr == CP0_BADVADDR ? mtc0_data : badvaddr_q;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      im_q       <= '0;
      ie_q       <= 1'b0;
      exl_q      <= 1'b0;
      bd_q       <= 1'b0;
      exc_code_q <= '0;
      ip_sw_q    <= '0;
      ip_hw_q    <= '0;
      epc_q      <= '0;
      badvaddr_q <= '0;
    end else begin
      im_q       <= im_d;
      ie_q       <= ie_d;
      exl_q      <= exl_d;
      bd_q       <= bd_d;
      exc_code_q <= exc_code_d;
      ip_sw_q    <= ip_sw_d;
      ip_hw_q    <= ip_hw_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
    end
  end
  always_comb begin
    cp0_status          = '0;
    cp0_status.bev      = 1'b1;
    cp0_status.im       = im_q;
    cp0_status.exl      = exl_q;
    cp0_status.ie       = ie_q;
    cause               = '0;
    cause.bd            = bd_q;
    cause.ti            = ti;
    cause.ip            = {ti, ip_hw_q, ip_sw_q};
    cause.exc_code      = exc_code_q;
  end
  always_comb begin
    case (mfc0_addr)
      CP0_BADVADDR: mfc0_rdata = badvaddr_q;
      CP0_COUNT:    mfc0_rdata = count;
      CP0_COMPARE:  mfc0_rdata = compare;
      CP0_STATUS:   mfc0_rdata = cp0_status;
      CP0_CAUSE:    mfc0_rdata = cause;
      CP0_EPC:      mfc0_rdata = epc_q;
      default:      mfc0_rdata = '0;
    endcase
  end
  assign interrupt_info = cause.ip & cp0_status.im;
  assign redirect_valid = !reset && (exc || is_eret);
  assign redirect_pc    = exc ? EXC_BASE + ((exception_info.location == LOC_REFILL && !exl_q) ? VEC_REFILL : VEC_GENERAL) : epc_q;
endmodule
